// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's load/store port.
//
// Accepts one request per valid/ready handshake and performs an RV32
// byte/half/word access on an internal word array. Size and signedness come
// from funct3. The response appears after a fixed WAIT_CYCLES latency and
// lasts one cycle. Only one request is in flight at a time.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : a misaligned H/W access returns rsp_err=1 and rdata=0, and a
//               misaligned store does not write.
//   undefined : misaligned low address bits are forced to zero and the access
//               proceeds.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   req_valid      request present (held stable by master until accepted)
//   req_ready      high only in IDLE
//   req_we         1 = store, 0 = load
//   req_addr       byte address, word index = req_addr[ADDR_W+1:2]
//   req_funct3     [1:0] size B/H/W/illegal, [2] unsigned load
//   req_wdata      right-justified store data
//   rsp_valid      one-cycle completion pulse
//   rsp_rdata      extended load data (0 for stores and errors)
//   rsp_err        illegal size or trapped misalignment, qualified by rsp_valid
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // WAIT lasts WAIT_CYCLES cycles; the counter leaves WAIT when it reads 0.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // State and captured request
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];

  logic [1:0]        w_state_d;
  logic [3:0]        w_cnt_d;
  logic              w_accept;
  logic [1:0]        w_req_size;
  logic              w_req_misalign;
  logic              w_req_err;
  logic [ADDR_W+1:0] w_req_addr;

  // Fields actually used for the access this cycle
  logic              w_acc_we;
  logic [ADDR_W+1:0] w_acc_addr;
  logic [1:0]        w_acc_size;
  logic              w_acc_uns;
  logic [31:0]       w_acc_wdata;
  logic              w_acc_err;

  logic [31:0]       w_word;
  logic [31:0]       w_load_data;
  logic [3:0]        w_be;
  logic [31:0]       w_st_lanes;
  logic              w_do_access;
  logic              w_do_write;

  assign w_accept   = req_valid & r_ready;
  assign w_req_size = req_funct3[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_req_misalign = ((w_req_size == SZ_H) && req_addr[0]) ||
                          ((w_req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign w_req_addr     = req_addr;
`else
  assign w_req_misalign = 1'b0;
  always_comb begin
    w_req_addr = req_addr;
    if (w_req_size == SZ_H) begin
      w_req_addr[0] = 1'b0;
    end else if (w_req_size == SZ_W) begin
      w_req_addr[1:0] = 2'b00;
    end
  end
`endif

  assign w_req_err = (w_req_size == 2'b11) || w_req_misalign;

  // With WAIT_CYCLES=0 the access happens on the accept edge itself, before
  // the request registers are loaded, so IDLE takes the fields from the port.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_acc_we    = req_we;
      w_acc_addr  = w_req_addr;
      w_acc_size  = w_req_size;
      w_acc_uns   = req_funct3[2];
      w_acc_wdata = req_wdata;
      w_acc_err   = w_req_err;
    end else begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_size  = r_size;
      w_acc_uns   = r_uns;
      w_acc_wdata = r_wdata;
      w_acc_err   = r_err;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_d = ST_RESP;
          end else begin
            w_state_d = ST_WAIT;
            w_cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_d = ST_RESP;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  // The access is performed on the edge that enters RESP
  assign w_do_access = (w_state_d == ST_RESP);
  assign w_do_write  = rst_n && w_do_access && w_acc_we && !w_acc_err;

  assign w_word = r_mem[w_acc_addr[ADDR_W+1:2]];

  // Load lane extraction and extension
  always_comb begin
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    w_load_data = 32'd0;
    case (w_acc_addr[1:0])
      2'd0:    v_byte = w_word[7:0];
      2'd1:    v_byte = w_word[15:8];
      2'd2:    v_byte = w_word[23:16];
      default: v_byte = w_word[31:24];
    endcase
    v_half = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_acc_size)
      SZ_B:    w_load_data = {{24{v_byte[7] & ~w_acc_uns}}, v_byte};
      SZ_H:    w_load_data = {{16{v_half[15] & ~w_acc_uns}}, v_half};
      SZ_W:    w_load_data = w_word;
      default: w_load_data = 32'd0;
    endcase
  end

  // Store byte enables and lane-replicated data
  always_comb begin
    w_be       = 4'b0000;
    w_st_lanes = w_acc_wdata;
    case (w_acc_size)
      SZ_B: begin
        w_be       = 4'b0001 << w_acc_addr[1:0];
        w_st_lanes = {4{w_acc_wdata[7:0]}};
      end
      SZ_H: begin
        w_be       = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_st_lanes = {2{w_acc_wdata[15:0]}};
      end
      SZ_W: begin
        w_be       = 4'b1111;
        w_st_lanes = w_acc_wdata;
      end
      default: begin
        w_be       = 4'b0000;
        w_st_lanes = w_acc_wdata;
      end
    endcase
  end

  // Control, request capture and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_wdata     <= 32'd0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ready <= (w_state_d == ST_IDLE);
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= w_req_addr;
        r_size  <= w_req_size;
        r_uns   <= req_funct3[2];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      r_rsp_valid <= w_do_access;
      r_rsp_err   <= w_do_access && w_acc_err;
      r_rsp_rdata <= (w_do_access && !w_acc_we && !w_acc_err) ? w_load_data : 32'd0;
    end
  end

  // Word array, not reset; unselected bytes keep their value
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_acc_addr[ADDR_W+1:2]][8*b +: 8] <= w_st_lanes[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int ADDR_W = 8;
  localparam int WV [3] = '{0, 1, 3};

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [2:0]        req_funct3 = 3'b0;
  logic [31:0]       req_wdata = 32'd0;

  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  er;
  logic [31:0] rd [3];

  int n_chk = 0;
  int n_err = 0;
  exp_t sb [$];
  vec_t vecs [$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request to all three instances at once; called at a negedge.
  task automatic do_req(input logic we, input logic [9:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, input logic [31:0] exp, input logic err,
                        input logic [31:0] exp0);
    int   t;
    int   lat [3];
    int   nrsp [3];
    logic [31:0] got [3];
    logic        gerr [3];
    exp_t e;
    t = 0;
    while (rdy !== 3'b111 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_req", 32'(rdy), 32'h7);
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    e.rdata = exp;
    e.err   = err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Disturb the request fields once accepted; they must not matter any more.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = 10'($urandom);
    req_funct3 = 3'($urandom);
    req_wdata  = $urandom;
    for (int i = 0; i < 3; i++) begin
      lat[i]  = -1;
      nrsp[i] = 0;
      got[i]  = 32'd0;
      gerr[i] = 1'b0;
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (vld[i] === 1'b1) begin
          nrsp[i]++;
          lat[i]  = k;
          got[i]  = rd[i];
          gerr[i] = er[i];
        end
      end
      if (vld[1] === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("w1_rdata", rd[1], e.rdata);
        chk("w1_err", 32'(er[1]), 32'(e.err));
      end
    end
    chk("w1_scoreboard_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w%0d_nrsp", WV[i]), 32'(nrsp[i]), 32'd1);
      chk($sformatf("w%0d_latency", WV[i]), 32'(lat[i]), 32'(1 + WV[i]));
    end
    chk("w0_rdata", got[0], exp0);
    chk("w0_err", 32'(gerr[0]), 32'(err));
    chk("w3_rdata", got[2], exp);
    chk("w3_err", 32'(gerr[2]), 32'(err));
  endtask

  task automatic add(input logic we, input logic [9:0] addr, input logic [2:0] f3,
                     input logic [31:0] wdata, input logic [31:0] exp, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata; v.exp = exp; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc [3];
    int nacc [3];

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(rdy), 32'h0);
    chk("reset_valid", 32'(vld), 32'h0);
    chk("reset_err", 32'(er), 32'h0);
    for (int i = 0; i < 3; i++) chk("reset_rdata", rd[i], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy), 32'h7);

    // Table: we, addr, funct3, wdata, expected rdata, expected err
    add(1, 10'h010, 3'b010, 32'hDEADBEEF, 32'h0, 0);
    add(0, 10'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    add(1, 10'h020, 3'b010, 32'h11223344, 32'h0, 0);
    add(1, 10'h023, 3'b000, 32'h00000080, 32'h0, 0);
    add(0, 10'h020, 3'b010, 32'h0, 32'h80223344, 0);
    add(0, 10'h023, 3'b000, 32'h0, 32'hFFFFFF80, 0);
    add(0, 10'h023, 3'b100, 32'h0, 32'h00000080, 0);
    add(1, 10'h030, 3'b010, 32'hA5A5A5A5, 32'h0, 0);
    add(1, 10'h032, 3'b001, 32'h0000BEEF, 32'h0, 0);
    add(0, 10'h032, 3'b001, 32'h0, 32'hFFFFBEEF, 0);
    add(0, 10'h032, 3'b101, 32'h0, 32'h0000BEEF, 0);
    add(0, 10'h030, 3'b010, 32'h0, 32'hBEEFA5A5, 0);
    add(0, 10'h030, 3'b110, 32'h0, 32'hBEEFA5A5, 0);
    add(1, 10'h031, 3'b000, 32'hFFFFFF7F, 32'h0, 0);
    add(0, 10'h031, 3'b000, 32'h0, 32'h0000007F, 0);
    add(1, 10'h030, 3'b011, 32'h00000000, 32'h0, 1);
    add(0, 10'h030, 3'b111, 32'h0, 32'h0, 1);
    add(0, 10'h030, 3'b010, 32'h0, 32'hBEEF7FA5, 0);
    add(1, 10'h040, 3'b010, 32'hCAFEF00D, 32'h0, 0);
    add(0, 10'h041, 3'b010, 32'h0, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP);
    add(1, 10'h042, 3'b010, 32'h01020304, 32'h0, TRAP);
    add(0, 10'h040, 3'b010, 32'h0, TRAP ? 32'hCAFEF00D : 32'h01020304, 0);
    add(0, 10'h043, 3'b001, 32'h0, TRAP ? 32'h0 : 32'h00000102, TRAP);
    add(0, 10'h041, 3'b001, 32'h0, TRAP ? 32'h0 : 32'h00000304, TRAP);
    add(0, 10'h043, 3'b000, 32'h0, TRAP ? 32'hFFFFFFCA : 32'h00000001, 0);
    add(1, 10'h041, 3'b001, 32'h00008001, 32'h0, TRAP);
    add(0, 10'h040, 3'b010, 32'h0, TRAP ? 32'hCAFEF00D : 32'h01028001, 0);
    add(1, 10'h3FC, 3'b010, 32'h5555AAAA, 32'h0, 0);
    add(0, 10'h3FE, 3'b001, 32'h0, 32'h00005555, 0);
    add(1, 10'h050, 3'b010, 32'h00000000, 32'h0, 0);
    add(1, 10'h051, 3'b000, 32'hAABBCC12, 32'h0, 0);
    add(0, 10'h050, 3'b010, 32'h0, 32'h00001200, 0);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, vecs[i].exp, vecs[i].err,
             vecs[i].exp);
    end

    // Back-to-back: req_valid held high; each instance accepts once per W+2 cycles.
    req_we     = 1'b0;
    req_addr   = 10'h010;
    req_funct3 = 3'b010;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      last_acc[j] = -1;
      nacc[j]     = 0;
    end
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (vld[j] === 1'b1) begin
          chk($sformatf("b2b_w%0d_latency", WV[j]), 32'(i - last_acc[j]), 32'(1 + WV[j]));
          chk($sformatf("b2b_w%0d_rdata", WV[j]), rd[j], 32'hDEADBEEF);
          chk($sformatf("b2b_w%0d_ready_in_resp", WV[j]), 32'(rdy[j]), 32'h0);
        end
        if (rdy[j] === 1'b1) begin
          if (last_acc[j] >= 0) begin
            chk($sformatf("b2b_w%0d_period", WV[j]), 32'(i - last_acc[j]), 32'(2 + WV[j]));
          end
          last_acc[j] = i;
          nacc[j]++;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_w0_accepts", 32'(nacc[0]), 32'd15);
    chk("b2b_w1_accepts", 32'(nacc[1]), 32'd10);
    chk("b2b_w3_accepts", 32'(nacc[2]), 32'd6);
    repeat (6) @(negedge clk);

    // Reset during WAIT of a store: W=1 and W=3 must never write.
    req_we     = 1'b1;
    req_addr   = 10'h050;
    req_funct3 = 3'b010;
    req_wdata  = 32'h12345678;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_w0_resp", 32'(vld[0]), 32'h1);
    chk("rst_mid_w1_wait", 32'(vld[1]), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(vld), 32'h0);
    chk("rst_mid_ready", 32'(rdy), 32'h0);
    @(negedge clk);
    chk("rst_mid_valid2", 32'(vld), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(rdy), 32'h7);
    chk("rst_mid_valid3", 32'(vld), 32'h0);
    do_req(1'b0, 10'h050, 3'b010, 32'h0, 32'h00001200, 1'b0, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
